// File: rtl/dm_store_buffer.sv
// dm_store_buffer
// ---------------
// Write buffer between the MEM-stage pipeline register and the single-port
// data memory. Word stores from the MEM stage go into a small FIFO. The FIFO
// drains one store per cycle whenever no load is using the DM address port.
// A load is compared against every buffered store. If one matches, it gets
// the youngest matching data, so it sees its own earlier stores even while
// they are still waiting to drain.
//
// Ports
//   clk, clr            clock, synchronous active-high reset
//   st_valid, ld_valid  MEM stage presents a store / load this cycle
//   addr, wd, pc        MEM-stage byte address (bits [1:0] ignored for
//                       matching), store data, instruction PC
//   dm_dr               DM combinational read data
//   stall               store could not be accepted; MEM stage must hold
//   ld_data             load result (forwarded or dm_dr)
//   dm_we, dm_addr,
//   dm_wd, dm_pc        DM write port and the PC tag for the store log
//   count, empty, full  buffer occupancy
//
// Handshake: a store transfers on a cycle where st_valid = 1 and stall = 0.
// stall is combinational and depends on this cycle's ld_valid and on the
// buffer state only. The MEM stage keeps st_valid, addr, wd and pc stable
// while stall = 1. Loads have no handshake: they always complete in the
// cycle they are presented.
//
// While ld_valid is high, it blocks draining, even when st_valid is also
// high. In that cycle the store wins the buffer and the load result is
// ignored upstream. DM gets no write that cycle, because the DM port is
// reserved for the load. This is why the FIFO can fill up under a stream of
// loads.

module dm_store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             st_valid,
    input  logic             ld_valid,
    input  logic [31:0]      addr,
    input  logic [31:0]      wd,
    input  logic [31:0]      pc,
    input  logic [31:0]      dm_dr,
    output logic             stall,
    output logic [31:0]      ld_data,
    output logic             dm_we,
    output logic [31:0]      dm_addr,
    output logic [31:0]      dm_wd,
    output logic [31:0]      dm_pc,
    output logic [PTR_W:0]   count,
    output logic             empty,
    output logic             full
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [29:0]      ent_addr [DEPTH];
    logic [31:0]      ent_wd   [DEPTH];
    logic [31:0]      ent_pc   [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    logic             drain_fire;
    logic             accept;
    logic [PTR_W-1:0] fwd_idx;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);

    // In the clr cycle nothing drains, so DM never sees a write from an entry
    // that is being discarded.
    assign drain_fire = !clr && !ld_valid && !empty;

    // A drain in the same cycle frees the head slot, so a full buffer can
    // still take a store without a bubble.
    assign accept = !clr && st_valid && (!full || drain_fire);
    assign stall  = st_valid && full && !drain_fire;

    // DM port: a drain when one fires, otherwise the raw MEM address (this
    // covers both loads and idle cycles).
    always_comb begin
        dm_we   = 1'b0;
        dm_addr = addr;
        dm_wd   = '0;
        dm_pc   = '0;
        if (drain_fire) begin
            dm_we   = 1'b1;
            dm_addr = {ent_addr[head], 2'b00};
            dm_wd   = ent_wd[head];
            dm_pc   = ent_pc[head];
        end
    end

    // Walk the entries from oldest to youngest. A later match overrides an
    // earlier one, so the entry nearest the tail wins.
    always_comb begin
        ld_data = dm_dr;
        fwd_idx = head;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head + PTR_W'(i);
            if (((PTR_W+1)'(i) < count) && (ent_addr[fwd_idx] == addr[31:2])) begin
                ld_data = ent_wd[fwd_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (accept) begin
                tail <= tail + 1'b1;
            end
            if (drain_fire) begin
                head <= head + 1'b1;
            end
            count <= count + {{PTR_W{1'b0}}, accept} - {{PTR_W{1'b0}}, drain_fire};
        end
    end

    // Entry payload needs no reset; count marks which slots are valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            ent_addr[tail] <= addr[31:2];
            ent_wd[tail]   <= wd;
            ent_pc[tail]   <= pc;
        end
    end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Testbench for dm_store_buffer. It applies a table of directed vectors with
// hand-computed expectations, then alternating store/load traffic, then
// random traffic. An occupancy/forwarding model and a DM-write scoreboard
// check every cycle.

module tb_dm_store_buffer;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk;
    logic             clr;
    logic             st_valid;
    logic             ld_valid;
    logic [31:0]      addr;
    logic [31:0]      wd;
    logic [31:0]      pc;
    logic [31:0]      dm_dr;
    logic             stall;
    logic [31:0]      ld_data;
    logic             dm_we;
    logic [31:0]      dm_addr;
    logic [31:0]      dm_wd;
    logic [31:0]      dm_pc;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;

    dm_store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .clr(clr), .st_valid(st_valid), .ld_valid(ld_valid),
        .addr(addr), .wd(wd), .pc(pc), .dm_dr(dm_dr),
        .stall(stall), .ld_data(ld_data), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wd(dm_wd), .dm_pc(dm_pc), .count(count), .empty(empty), .full(full)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    // Expected DM writes {addr, wd, pc}, in drain order.
    logic [95:0] exp_q[$];
    // Model of buffer contents {addr, wd, pc}, oldest first.
    logic [95:0] model_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        c_clr;
        logic        c_st;
        logic        c_ld;
        logic [31:0] c_addr;
        logic [31:0] c_wd;
        logic [31:0] c_pc;
        logic [31:0] c_dr;
        logic        e_stall;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic [31:0] e_pc;
        logic [31:0] e_ld;
        int          e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic c, input logic s, input logic l,
                           input logic [31:0] a, input logic [31:0] w,
                           input logic [31:0] p, input logic [31:0] d,
                           input logic es, input logic ew,
                           input logic [31:0] ea, input logic [31:0] ewd,
                           input logic [31:0] ep, input logic [31:0] el,
                           input int ec);
        vec_t v;
        v.c_clr = c;  v.c_st = s;  v.c_ld = l;
        v.c_addr = a; v.c_wd = w;  v.c_pc = p; v.c_dr = d;
        v.e_stall = es; v.e_we = ew; v.e_addr = ea; v.e_wd = ewd;
        v.e_pc = ep; v.e_ld = el; v.e_cnt = ec;
        vecs.push_back(v);
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply(input logic c, input logic s, input logic l,
                         input logic [31:0] a, input logic [31:0] w,
                         input logic [31:0] p, input logic [31:0] d);
        @(negedge clk);
        clr = c; st_valid = s; ld_valid = l;
        addr = a; wd = w; pc = p; dm_dr = d;
        #1;
    endtask

    // Checks this cycle's outputs against the model and scoreboard, then
    // advances the model to match what the coming edge will do.
    task automatic model_step();
        int          sz;
        bit          m_drain;
        bit          m_acc;
        logic [31:0] m_ld;
        logic [95:0] e;
        sz      = model_q.size();
        m_drain = !clr && !ld_valid && (sz > 0);
        m_acc   = !clr && st_valid && ((sz < DEPTH) || m_drain);
        m_ld    = dm_dr;
        for (int i = 0; i < sz; i++) begin
            if (model_q[i][95:66] == addr[31:2]) m_ld = model_q[i][63:32];
        end
        chk("m_count", 32'(count), 32'(sz));
        chk("m_empty", 32'(empty), 32'(sz == 0));
        chk("m_full",  32'(full),  32'(sz == DEPTH));
        chk("m_stall", 32'(stall), 32'(st_valid && (sz == DEPTH) && !m_drain));
        chk("m_we",    32'(dm_we), 32'(m_drain));
        if (ld_valid && !st_valid) chk("m_ld_data", ld_data, m_ld);
        if (dm_we) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_write: got addr %h with no write expected", dm_addr);
            end else begin
                e = exp_q.pop_front();
                chk("sb_addr", dm_addr, e[95:64]);
                chk("sb_wd",   dm_wd,   e[63:32]);
                chk("sb_pc",   dm_pc,   e[31:0]);
            end
        end
        if (clr) begin
            model_q.delete();
            exp_q.delete();
        end else begin
            if (m_drain) void'(model_q.pop_front());
            if (m_acc) begin
                model_q.push_back({addr[31:2], 2'b00, wd, pc});
                exp_q.push_back({addr[31:2], 2'b00, wd, pc});
            end
        end
    endtask

    task automatic drive_cycle(input logic c, input logic s, input logic l,
                               input logic [31:0] a, input logic [31:0] w,
                               input logic [31:0] p, input logic [31:0] d);
        apply(c, s, l, a, w, p, d);
        model_step();
        @(posedge clk);
    endtask

    // ---------------- test ----------------
    initial begin
        int          stores_issued;
        logic [31:0] a;
        int          r;

        clr = 1'b1; st_valid = 1'b0; ld_valid = 1'b0;
        addr = '0; wd = '0; pc = '0; dm_dr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full),  32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_we",    32'(dm_we), 32'd0);

        //       clr st ld addr      wd           pc        dr             stall we addr      wd           pc        ld            cnt
        add_vec(0, 0, 0, 32'h00, 32'h0,        32'h0,    32'h0BAD_0000, 0, 0, 32'h00, 32'h0,        32'h0,    32'h0BAD_0000, 0);
        add_vec(0, 1, 0, 32'h10, 32'hAAAA_0001, 32'h3000, 32'h0,         0, 0, 32'h10, 32'h0,        32'h0,    32'h0,         0);
        add_vec(0, 0, 0, 32'h00, 32'h0,        32'h0,    32'h1234_5678, 0, 1, 32'h10, 32'hAAAA_0001, 32'h3000, 32'h1234_5678, 1);
        add_vec(0, 0, 0, 32'h00, 32'h0,        32'h0,    32'h0,         0, 0, 32'h00, 32'h0,        32'h0,    32'h0,         0);
        add_vec(0, 1, 0, 32'h20, 32'h1,        32'h3004, 32'h0,         0, 0, 32'h20, 32'h0,        32'h0,    32'h0,         0);
        add_vec(0, 1, 0, 32'h20, 32'h2,        32'h3008, 32'h0,         0, 1, 32'h20, 32'h1,        32'h3004, 32'h1,         1);
        add_vec(0, 0, 1, 32'h20, 32'h0,        32'h0,    32'h5555,      0, 0, 32'h20, 32'h0,        32'h0,    32'h2,         1);
        add_vec(0, 0, 1, 32'h24, 32'h0,        32'h0,    32'hDEAD_BEEF, 0, 0, 32'h24, 32'h0,        32'h0,    32'hDEAD_BEEF, 1);
        add_vec(0, 0, 0, 32'h00, 32'h0,        32'h0,    32'h0,         0, 1, 32'h20, 32'h2,        32'h3008, 32'h0,         1);
        add_vec(0, 0, 0, 32'h00, 32'h0,        32'h0,    32'h0,         0, 0, 32'h00, 32'h0,        32'h0,    32'h0,         0);
        add_vec(0, 1, 1, 32'h50, 32'h11,       32'h4000, 32'h0,         0, 0, 32'h50, 32'h0,        32'h0,    32'h0,         0);
        add_vec(0, 1, 1, 32'h54, 32'h22,       32'h4004, 32'h0,         0, 0, 32'h54, 32'h0,        32'h0,    32'h0,         1);
        add_vec(0, 1, 1, 32'h58, 32'h33,       32'h4008, 32'h0,         0, 0, 32'h58, 32'h0,        32'h0,    32'h0,         2);
        add_vec(0, 1, 1, 32'h5C, 32'h44,       32'h400C, 32'h0,         0, 0, 32'h5C, 32'h0,        32'h0,    32'h0,         3);
        add_vec(0, 1, 1, 32'h60, 32'h99,       32'h4020, 32'h0,         1, 0, 32'h60, 32'h0,        32'h0,    32'h0,         4);
        add_vec(0, 1, 0, 32'h60, 32'h55,       32'h4010, 32'h0,         0, 1, 32'h50, 32'h11,       32'h4000, 32'h0,         4);
        add_vec(0, 0, 1, 32'h60, 32'h0,        32'h0,    32'h7777,      0, 0, 32'h60, 32'h0,        32'h0,    32'h55,        4);
        add_vec(0, 0, 1, 32'h54, 32'h0,        32'h0,    32'h7777,      0, 0, 32'h54, 32'h0,        32'h0,    32'h22,        4);
        add_vec(0, 0, 0, 32'h00, 32'h0,        32'h0,    32'h0,         0, 1, 32'h54, 32'h22,       32'h4004, 32'h0,         4);
        add_vec(1, 0, 0, 32'h00, 32'h0,        32'h0,    32'h0,         0, 0, 32'h00, 32'h0,        32'h0,    32'h0,         3);
        add_vec(0, 0, 0, 32'h00, 32'h0,        32'h0,    32'h0,         0, 0, 32'h00, 32'h0,        32'h0,    32'h0,         0);

        foreach (vecs[i]) begin
            apply(vecs[i].c_clr, vecs[i].c_st, vecs[i].c_ld, vecs[i].c_addr,
                  vecs[i].c_wd, vecs[i].c_pc, vecs[i].c_dr);
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].e_cnt == 0));
            chk($sformatf("v%0d_full", i),  32'(full),  32'(vecs[i].e_cnt == DEPTH));
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d_we", i),    32'(dm_we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d_addr", i),  dm_addr,    vecs[i].e_addr);
            chk($sformatf("v%0d_wd", i),    dm_wd,      vecs[i].e_wd);
            chk($sformatf("v%0d_pc", i),    dm_pc,      vecs[i].e_pc);
            chk($sformatf("v%0d_ld", i),    ld_data,    vecs[i].e_ld);
            model_step();
            @(posedge clk);
        end

        // Alternating store/load to 0x40 / 0x44.
        stores_issued = 0;
        for (int i = 0; i < 8; i++) begin
            a = ((i / 2) % 2 == 1) ? 32'h44 : 32'h40;
            if (i % 2 == 0) begin
                stores_issued++;
                drive_cycle(0, 1, 0, a, $urandom, 32'h5000 + 32'(i * 4), $urandom);
            end else begin
                drive_cycle(0, 0, 1, a, 32'h0, 32'h0, $urandom);
            end
            #1;
            chk("alt_count_bound", 32'(count <= stores_issued), 32'd1);
        end

        // Random mixed traffic over a small address set to force forwarding hits.
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 3);
            a = 32'h40 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
            drive_cycle(($urandom_range(0, 29) == 0), (r == 1 || r == 3), (r == 2 || r == 3),
                        a, $urandom, 32'h6000 + 32'(i * 4), $urandom);
        end

        // Drain to empty with a bounded number of idle cycles.
        for (int i = 0; i < 2 * DEPTH; i++) begin
            drive_cycle(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        end
        #1;
        chk("final_empty", 32'(empty), 32'd1);
        chk("final_sb_left", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
